// File: rtl/prog_loader.sv
// Serial programming front end: deserialises a framed byte stream (magic, length,
// payload, XOR checksum) and strobes each payload byte into the controller.
module prog_loader #(
    parameter int         MAX_BYTES   = 64,
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       ser_sel,
    input  logic       ser_sck,
    input  logic       ser_sdi,
    output logic       prog_enable,
    output logic [7:0] prog_data,
    output logic       core_run,
    output logic       busy,
    output logic       error
);
    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sel_sync_q, sck_sync_q, sdi_sync_q;
    logic       sel_prev_q, sck_prev_q;
    logic       sel_s, sck_s, sdi_s;
    logic       sel_rise, sel_fall, sck_rise;
    logic [7:0] shifted, cnt_inc;

    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] prog_data_q, prog_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_ready_q, byte_ready_d;
    logic       prog_enable_q, prog_enable_d;
    logic       core_run_q, core_run_d;
    logic       error_q, error_d;

    assign sel_s    = sel_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sel_rise = sel_s & ~sel_prev_q;
    assign sel_fall = ~sel_s & sel_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign shifted  = {shift_q[6:0], sdi_s};
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d       = state_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        prog_data_d   = prog_data_q;
        bit_cnt_d     = bit_cnt_q;
        byte_ready_d  = 1'b0;
        prog_enable_d = 1'b0;
        core_run_d    = core_run_q;
        error_d       = error_q;

        // The strobe is launched on the 8th bit so it lines up with byte_ready.
        if (sck_rise && sel_s) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_ready_d = 1'b1;
                byte_d       = shifted;
                if (state_q == DATA) begin
                    prog_enable_d = 1'b1;
                    prog_data_d   = shifted;
                end
            end
        end

        if (byte_ready_q) begin
            unique case (state_q)
                HDR:  state_d = (byte_q == MAGIC) ? LEN : ERR;
                LEN: begin
                    if (byte_q != 8'd0 && byte_q <= MAX_LEN) begin
                        len_d   = byte_q;
                        cnt_d   = 8'd0;
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ byte_q;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) state_d = CSUM;
                end
                CSUM: begin
                    if (byte_q == csum_q) begin
                        state_d    = DONE;
                        core_run_d = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: ;
            endcase
        end

        // Abort is applied after byte processing so a final checksum byte still lands.
        if (sel_fall && (state_d inside {HDR, LEN, DATA, CSUM})) state_d = ERR;

        if (state_d == ERR) begin
            error_d    = 1'b1;
            core_run_d = 1'b0;
        end

        if (sel_rise) begin
            state_d       = HDR;
            bit_cnt_d     = 3'd0;
            cnt_d         = 8'd0;
            csum_d        = 8'd0;
            error_d       = 1'b0;
            core_run_d    = 1'b0;
            byte_ready_d  = 1'b0;
            prog_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: synchronous reset clears every flop, synchronisers included, so no stale edge fires after rst.
        if (rst) begin
            state_q       <= IDLE;
            sel_sync_q    <= '0;
            sck_sync_q    <= '0;
            sdi_sync_q    <= '0;
            sel_prev_q    <= 1'b0;
            sck_prev_q    <= 1'b0;
            shift_q       <= '0;
            byte_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            csum_q        <= '0;
            prog_data_q   <= '0;
            bit_cnt_q     <= '0;
            byte_ready_q  <= 1'b0;
            prog_enable_q <= 1'b0;
            core_run_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sel_sync_q    <= {sel_sync_q[SYNC_STAGES-2:0], ser_sel};
            sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], ser_sck};
            sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], ser_sdi};
            sel_prev_q    <= sel_s;
            sck_prev_q    <= sck_s;
            state_q       <= state_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            csum_q        <= csum_d;
            prog_data_q   <= prog_data_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_ready_q  <= byte_ready_d;
            prog_enable_q <= prog_enable_d;
            core_run_q    <= core_run_d;
            error_q       <= error_d;
        end
    end

    assign prog_enable = prog_enable_q;
    assign prog_data   = prog_data_q;
    assign core_run    = core_run_q;
    assign error       = error_q;
    assign busy        = state_q inside {HDR, LEN, DATA, CSUM};

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level reference model predicts strobed
// bytes and final status; a monitor pops expected bytes whenever prog_enable fires.
module tb_prog_loader;
    localparam int MAX_BYTES = 64;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       ser_sel = 1'b0;
    logic       ser_sck = 1'b0;
    logic       ser_sdi = 1'b0;
    logic       prog_enable;
    logic [7:0] prog_data;
    logic       core_run;
    logic       busy;
    logic       error;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];

    prog_loader #(.MAX_BYTES(MAX_BYTES), .MAGIC(8'hA5), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .rst        (rst),
        .ser_sel    (ser_sel),
        .ser_sck    (ser_sck),
        .ser_sdi    (ser_sdi),
        .prog_enable(prog_enable),
        .prog_data  (prog_data),
        .core_run   (core_run),
        .busy       (busy),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted payload byte.
    always @(negedge clock) begin
        if (prog_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got %0h expected none", prog_data);
            end else begin
                check("strobe_data", {24'd0, prog_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Reference model: decide from whole bytes received whether the frame is good,
    // and queue every payload byte that arrives before any error.
    task automatic model(input int nbits, output bit ok);
        int         nfull;
        int         len;
        logic [7:0] cs;
        nfull = nbits / 8;
        cs    = 8'd0;
        ok    = 1'b0;
        if (nfull < 1 || frame_q[0] != 8'hA5) return;
        if (nfull < 2) return;
        len = int'(frame_q[1]);
        if (len == 0 || len > MAX_BYTES) return;
        for (int i = 0; i < len; i++) begin
            if (2 + i >= nfull) return;
            exp_q.push_back(frame_q[2 + i]);
            cs = cs ^ frame_q[2 + i];
        end
        if (2 + len >= nfull) return;
        ok = (frame_q[2 + len] == cs);
    endtask

    task automatic build_frame(input int len);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'd0;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            cs = cs ^ b;
        end
        frame_q.push_back(cs);
    endtask

    task automatic send_bits(input int nbits);
        logic [7:0] b;
        for (int k = 0; k < nbits; k++) begin
            b = frame_q[k / 8];
            ser_sdi = b[7 - (k % 8)];
            repeat (4) @(posedge clock);
            #1 ser_sck = 1'b1;
            repeat (4) @(posedge clock);
            #1 ser_sck = 1'b0;
        end
    endtask

    task automatic check_status(input string name, input bit ok);
        check({name, "_error"}, {31'd0, error}, {31'd0, ~ok});
        check({name, "_core_run"}, {31'd0, core_run}, {31'd0, ok});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_strobes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input string name, input int nbits);
        bit ok;
        model(nbits, ok);
        @(posedge clock);
        #1 ser_sel = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check({name, "_busy_in_frame"}, {31'd0, busy}, 32'd1);
        send_bits(nbits);
        repeat (6) @(posedge clock);
        #1 ser_sel = 1'b0;
        repeat (20) @(negedge clock);
        check_status(name, ok);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_prog_enable"}, {31'd0, prog_enable}, 32'd0);
        check({name, "_prog_data"}, {24'd0, prog_data}, 32'd0);
        check({name, "_core_run"}, {31'd0, core_run}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int mode;
        int len;
        int nbits;
        logic [7:0] r;

        repeat (5) @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        check_all_zero("reset");

        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("good_frame", 48);

        frame_q = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
        run_frame("bad_csum", 40);

        frame_q = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("bad_magic", 48);

        frame_q = '{8'hA5, 8'h00, 8'h11, 8'h11};
        run_frame("len_zero", 32);

        frame_q = '{8'hA5, 8'h41, 8'h11, 8'h22};
        run_frame("len_over_max", 32);

        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("sel_drop", 28);
        run_frame("recover_good", 48);

        // Reset mid-DATA: one byte strobed, second byte half shifted in.
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        begin
            bit ok_unused;
            model(28, ok_unused);
        end
        @(posedge clock);
        #1 ser_sel = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        send_bits(28);
        repeat (10) @(posedge clock);
        #1 rst = 1'b1;
        ser_sel = 1'b0;
        ser_sck = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_all_zero("rst_mid_data");
        check("rst_strobes_left", exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1 rst = 1'b0;
        repeat (5) @(posedge clock);
        run_frame("after_rst_good", 48);

        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(MAX_BYTES));
        for (int i = 0; i < MAX_BYTES; i++) frame_q.push_back(8'(i));
        frame_q.push_back(8'h00);
        run_frame("max_frame", frame_q.size() * 8);

        for (int t = 0; t < 24; t++) begin
            mode = int'($urandom_range(0, 5));
            len  = int'($urandom_range(1, 12));
            build_frame(len);
            nbits = frame_q.size() * 8;
            case (mode)
                1: begin
                    r = 8'($urandom_range(1, 255));
                    frame_q[0] = frame_q[0] ^ r;
                end
                2: frame_q[1] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_BYTES + 1, 255));
                3: begin
                    r = 8'($urandom_range(1, 255));
                    frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ r;
                end
                4: nbits = int'($urandom_range(1, nbits - 1));
                5: begin
                    frame_q.push_back(8'($urandom));
                    frame_q.push_back(8'($urandom));
                    nbits = nbits + int'($urandom_range(1, 16));
                end
                default: ;
            endcase
            run_frame($sformatf("rand%0d_m%0d", t, mode), nbits);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
